// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder controller.
package nibble_serial_add_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_nslice(input int width);
    return width / SLICE_W;
  endfunction

  // A single-nibble operand still needs a 1-bit index register.
  function automatic int calc_idx_w(input int nslice);
    return (nslice <= 1) ? 1 : $clog2(nslice);
  endfunction

endpackage

// File: rtl/add_slice4.sv
// Combinational 4-bit ripple-carry adder chained from full-adder cells.
module add_slice4
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);
  logic [SLICE_W:0] c;

  assign c[0] = cin;
  assign cout = c[SLICE_W];

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end
endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract done one nibble per clock through a single shared 4-bit slice,
// LSB nibble first, with the carry held in a register between passes.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             busy
);
  localparam int NSLICE = calc_nslice(WIDTH);
  localparam int IDX_W  = calc_idx_w(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if ((WIDTH < SLICE_W) || (WIDTH % SLICE_W != 0)) begin : g_width_chk
    $fatal(1, "nibble_serial_add_ctrl: WIDTH must be a positive multiple of 4");
  end

  state_e                          state_q;
  logic [NSLICE-1:0][SLICE_W-1:0]  a_q, b_q, sum_q;
  logic                            carry_q, cout_q;
  logic [IDX_W-1:0]                idx_q;

  logic [WIDTH-1:0]   b_d;
  logic               accept;
  logic [SLICE_W-1:0] s_sum;
  logic               s_cout;

  // Subtract is A + ~B + 1: invert B at load and seed the carry with in_sub.
  assign b_d    = in_sub ? ~in_b : in_b;
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = {cout_q, sum_q};

  add_slice4 u_slice (
    .a   (a_q[idx_q]),
    .b   (b_q[idx_q]),
    .cin (carry_q),
    .sum (s_sum),
    .cout(s_cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_q <= RUN;
            a_q     <= in_a;
            b_q     <= b_d;
            carry_q <= in_sub;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
          end else if (state_q == DONE && out_ready) begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sum_q[idx_q] <= s_sum;
          carry_q      <= s_cout;
          idx_q        <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_q  <= s_cout;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench with a result scoreboard for the nibble-serial adder controller.
module tb_nibble_serial_add_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_sub;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready, busy;
  logic [W:0]   out_sum;

  int checks = 0;
  int errors = 0;
  logic [W:0] sb[$];

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .busy     (busy)
  );

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    if (sub) return {(a >= b), W'(a - b)};
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request from IDLE; the accept edge is the next posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input bit push);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    #1;
    chk("accept_ready", 32'(in_ready), 32'd1);
    if (push) sb.push_back(model(a, b, sub));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the accepting edge; counts clocks until out_valid.
  task automatic run_phase(input string tag, input bit scramble);
    int cyc = 0;
    while (!out_valid && cyc < 40) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_rdy_run"}, 32'(in_ready), 32'd0);
      if (scramble) begin
        in_a = W'($urandom); in_b = W'($urandom);
        in_valid = ~in_valid; in_sub = ~in_sub;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(cyc), 32'd4);
  endtask

  task automatic check_result(input string tag);
    logic [W:0] exp;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      exp = sb.pop_front();
      chk({tag, "_sum"}, 32'(out_sum), 32'(exp));
      chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle"}, {29'd0, busy, in_ready, out_valid}, 32'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] held;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    issue(16'h1234, 16'h4321, 1'b0, 1'b1);
    run_phase("t1", 1'b0); check_result("t1"); consume("t1");

    issue(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    run_phase("t2", 1'b0); check_result("t2"); consume("t2");

    issue(16'h0005, 16'h0007, 1'b1, 1'b1);
    run_phase("t3a", 1'b0); check_result("t3a"); consume("t3a");
    issue(16'h0007, 16'h0005, 1'b1, 1'b1);
    run_phase("t3b", 1'b0); check_result("t3b"); consume("t3b");

    // Stall in DONE, then hand off back-to-back on the releasing edge.
    issue(16'h00FF, 16'h0F01, 1'b0, 1'b1);
    run_phase("t4", 1'b0); check_result("t4");
    held = out_sum;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_sum", 32'(out_sum), 32'(held));
      chk("t4_hold_rdy", 32'(in_ready), 32'd0);
    end
    in_a = 16'h0001; in_b = 16'h0001; in_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    sb.push_back(model(16'h0001, 16'h0001, 1'b0));
    #1;
    chk("t4_b2b_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t4_b2b_run", {30'd0, busy, out_valid}, 32'b10);
    run_phase("t4b", 1'b0); check_result("t4b"); consume("t4b");

    // Reset in the second RUN cycle abandons the operation.
    issue(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_out_sum", 32'(out_sum), 32'd0);
    @(negedge clk); reset = 1'b0;
    issue(16'h0003, 16'h0004, 1'b0, 1'b1);
    run_phase("t5", 1'b0); check_result("t5"); consume("t5");

    // Input churn during RUN must not disturb the result in flight.
    issue(16'h1111, 16'h2222, 1'b0, 1'b1);
    run_phase("t6", 1'b1); check_result("t6"); consume("t6");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
